// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS_PP pipeline front end.
package mips_pkg;

    localparam int unsigned     INSTR_W          = 32;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned     PC_INC           = 4;

    // Source of the next instruction-memory request, highest priority first.
    typedef enum logic [1:0] {
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_BOOT,
        SEL_SEQ
    } fetch_sel_e;

endpackage

// File: rtl/mips_perf_counter.sv
// Free-running event counter; wraps modulo 2^CNT_W.
module mips_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one event per cycle while inc is high; cleared by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read imem whose
// output register doubles as the IF/ID register, and handles stall/redirect.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned   AW         = 32,
    parameter logic [AW-1:0] RESET_PC   = AW'(DEFAULT_RESET_PC),
    parameter bit            DELAY_SLOT = 1'b1,
    parameter int unsigned   CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [AW-1:0]      redirect_pc,
    output logic               imem_en,
    output logic [AW-1:0]      imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] id_instr,
    output logic [AW-1:0]      id_pc,
    output logic [AW-1:0]      id_pc_plus4,
    output logic               id_valid,
    output logic               misalign_err,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   bubble_count
);

    logic [AW-1:0] fetch_pc_q;
    logic          live_q;
    logic          boot_q;
    logic          err_q;

    fetch_sel_e    sel;
    logic          req_en;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] seq_pc;
    logic [AW-1:0] target_pc;
    logic          misaligned;

    assign seq_pc     = fetch_pc_q + AW'(PC_INC);
    assign target_pc  = {redirect_pc[AW-1:2], 2'b00};
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Pick the request source: a redirect beats a stall, which beats the boot fetch.
    always_comb begin
        sel = SEL_SEQ;
        if (redirect_valid) begin
            sel = SEL_REDIRECT;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (boot_q) begin
            sel = SEL_BOOT;
        end
    end

    // Translate the selected source into the imem request for this cycle.
    always_comb begin
        req_en   = 1'b1;
        req_addr = fetch_pc_q;
        case (sel)
            SEL_REDIRECT: req_addr = target_pc;
            SEL_HOLD:     req_en   = 1'b0;
            SEL_BOOT:     req_addr = RESET_PC;
            SEL_SEQ:      req_addr = seq_pc;
            default:      req_en   = 1'b0;
        endcase
    end

    // Track the address whose data the imem will present next cycle, plus the sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            live_q     <= 1'b0;
            boot_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (req_en) begin
                fetch_pc_q <= req_addr;
                live_q     <= 1'b1;
                boot_q     <= 1'b0;
            end
            if (misaligned) begin
                err_q <= 1'b1;
            end
        end
    end

    // The imem stays idle while reset is held so no request escapes the cleared state.
    assign imem_en      = req_en && reset;
    assign imem_addr    = req_addr;

    assign id_valid     = live_q && !(redirect_valid && !DELAY_SLOT);
    assign id_instr     = id_valid ? imem_rdata : NOP_INSTR;
    assign id_pc        = fetch_pc_q;
    assign id_pc_plus4  = seq_pc;
    assign misalign_err = err_q;

    mips_perf_counter #(
        .CNT_W (CNT_W)
    ) u_fetch_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (id_valid && !stall),
        .count (fetch_count)
    );

    mips_perf_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (!id_valid && !stall),
        .count (bubble_count)
    );

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Testbench for mips_fetch_stage: three instances (delay slot on, delay slot off,
// reset PC at the top of memory) share one stimulus stream and are compared each
// cycle against a transaction-level reference model.
module tb_mips_fetch_stage;

    localparam int N = 3;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [N-1:0] imem_en;
    logic [N-1:0] id_valid;
    logic [N-1:0] misalign_err;
    logic [31:0]  imem_addr    [N];
    logic [31:0]  imem_rdata   [N];
    logic [31:0]  id_instr     [N];
    logic [31:0]  id_pc        [N];
    logic [31:0]  id_pc_plus4  [N];
    logic [31:0]  fetch_count  [N];
    logic [31:0]  bubble_count [N];

    // Reference model: address of the word sitting in ID, the next sequential
    // fetch address, and the bookkeeping the stage must expose.
    logic [31:0] m_pc   [N];
    logic [31:0] m_next [N];
    logic [31:0] m_fc   [N];
    logic [31:0] m_bc   [N];
    bit          m_live [N];
    bit          m_err  [N];

    int check_count = 0;
    int pass_count  = 0;

    function automatic logic [31:0] rpc_of(input int i);
        return (i == 2) ? 32'hFFFF_FFFC : 32'h0000_0000;
    endfunction

    function automatic bit ds_of(input int i);
        return (i != 1);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a >> 2) | 32'hA000_0000;
    endfunction

    mips_fetch_stage #(.AW(32), .RESET_PC(32'h0), .DELAY_SLOT(1'b1), .CNT_W(32)) u_dut0 (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(imem_en[0]), .imem_addr(imem_addr[0]),
        .imem_rdata(imem_rdata[0]), .id_instr(id_instr[0]), .id_pc(id_pc[0]),
        .id_pc_plus4(id_pc_plus4[0]), .id_valid(id_valid[0]), .misalign_err(misalign_err[0]),
        .fetch_count(fetch_count[0]), .bubble_count(bubble_count[0])
    );

    mips_fetch_stage #(.AW(32), .RESET_PC(32'h0), .DELAY_SLOT(1'b0), .CNT_W(32)) u_dut1 (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(imem_en[1]), .imem_addr(imem_addr[1]),
        .imem_rdata(imem_rdata[1]), .id_instr(id_instr[1]), .id_pc(id_pc[1]),
        .id_pc_plus4(id_pc_plus4[1]), .id_valid(id_valid[1]), .misalign_err(misalign_err[1]),
        .fetch_count(fetch_count[1]), .bubble_count(bubble_count[1])
    );

    mips_fetch_stage #(.AW(32), .RESET_PC(32'hFFFF_FFFC), .DELAY_SLOT(1'b1), .CNT_W(32)) u_dut2 (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(imem_en[2]), .imem_addr(imem_addr[2]),
        .imem_rdata(imem_rdata[2]), .id_instr(id_instr[2]), .id_pc(id_pc[2]),
        .id_pc_plus4(id_pc_plus4[2]), .id_valid(id_valid[2]), .misalign_err(misalign_err[2]),
        .fetch_count(fetch_count[2]), .bubble_count(bubble_count[2])
    );

    // Synchronous-read instruction memories, one per instance; hold data when disabled.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (imem_en[i]) begin
                imem_rdata[i] <= word_at(imem_addr[i]);
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pc[i]   = rpc_of(i);
            m_next[i] = rpc_of(i);
            m_fc[i]   = '0;
            m_bc[i]   = '0;
            m_live[i] = 1'b0;
            m_err[i]  = 1'b0;
        end
    endtask

    // Compare every output of every instance with what the model predicts right now.
    task automatic check_all();
        logic [31:0] tgt;
        bit          exp_valid;
        bit          exp_en;
        logic [31:0] exp_addr;
        tgt = {redirect_pc[31:2], 2'b00};
        for (int i = 0; i < N; i++) begin
            exp_valid = m_live[i] && !(redirect_valid && !ds_of(i));
            exp_en    = redirect_valid || !stall;
            exp_addr  = redirect_valid ? tgt : (stall ? m_pc[i] : m_next[i]);
            check_output($sformatf("u%0d.imem_en", i), {31'b0, imem_en[i]}, {31'b0, exp_en});
            if (exp_en) begin
                check_output($sformatf("u%0d.imem_addr", i), imem_addr[i], exp_addr);
            end
            check_output($sformatf("u%0d.id_valid", i), {31'b0, id_valid[i]}, {31'b0, exp_valid});
            check_output($sformatf("u%0d.id_instr", i), id_instr[i], exp_valid ? word_at(m_pc[i]) : 32'h0);
            check_output($sformatf("u%0d.id_pc", i), id_pc[i], m_pc[i]);
            check_output($sformatf("u%0d.id_pc_plus4", i), id_pc_plus4[i], m_pc[i] + 32'd4);
            check_output($sformatf("u%0d.misalign_err", i), {31'b0, misalign_err[i]}, {31'b0, m_err[i]});
            check_output($sformatf("u%0d.fetch_count", i), fetch_count[i], m_fc[i]);
            check_output($sformatf("u%0d.bubble_count", i), bubble_count[i], m_bc[i]);
        end
    endtask

    // Advance the model across one clock edge using the inputs that were applied.
    task automatic model_step();
        logic [31:0] tgt;
        logic [31:0] fetched;
        bit          vis;
        tgt = {redirect_pc[31:2], 2'b00};
        for (int i = 0; i < N; i++) begin
            vis = m_live[i] && !(redirect_valid && !ds_of(i));
            if (!stall) begin
                if (vis) m_fc[i] = m_fc[i] + 1;
                else     m_bc[i] = m_bc[i] + 1;
            end
            if (redirect_valid || !stall) begin
                fetched   = redirect_valid ? tgt : m_next[i];
                m_pc[i]   = fetched;
                m_next[i] = fetched + 32'd4;
                m_live[i] = 1'b1;
            end
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) m_err[i] = 1'b1;
        end
    endtask

    // One cycle: drive inputs, check mid-cycle, take the edge, update the model.
    task automatic apply_stimulus(input bit s, input bit r, input logic [31:0] pc);
        stall          = s;
        redirect_valid = r;
        redirect_pc    = pc;
        #4;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_state(input string phase);
        for (int i = 0; i < N; i++) begin
            check_output($sformatf("%s.u%0d.imem_en", phase, i), {31'b0, imem_en[i]}, 32'h0);
            check_output($sformatf("%s.u%0d.id_valid", phase, i), {31'b0, id_valid[i]}, 32'h0);
            check_output($sformatf("%s.u%0d.id_instr", phase, i), id_instr[i], 32'h0);
            check_output($sformatf("%s.u%0d.id_pc", phase, i), id_pc[i], rpc_of(i));
            check_output($sformatf("%s.u%0d.misalign_err", phase, i), {31'b0, misalign_err[i]}, 32'h0);
            check_output($sformatf("%s.u%0d.fetch_count", phase, i), fetch_count[i], 32'h0);
            check_output($sformatf("%s.u%0d.bubble_count", phase, i), bubble_count[i], 32'h0);
        end
    endtask

    task automatic run_random(input int cycles);
        bit          s;
        bit          r;
        logic [31:0] pc;
        for (int k = 0; k < cycles; k++) begin
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 6) == 0);
            pc = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 255));
            apply_stimulus(s, r, pc);
        end
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        reset = 1'b1;

        // Straight-line fetch out of reset, including the wrap instance.
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("boot.id_instr", id_instr[0], 32'hA000_0001);
        check_output("wrap.id_pc", id_pc[2], 32'h0000_0000);
        check_output("wrap.id_pc_plus4", id_pc_plus4[2], 32'h0000_0004);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("boot.fetch_count", fetch_count[0], 32'd3);
        check_output("boot.bubble_count", bubble_count[0], 32'd1);
        check_output("boot.id_pc", id_pc[0], 32'h0000_000C);

        // Three stalled cycles hold ID and the counters.
        repeat (3) apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("stall.id_pc", id_pc[0], 32'h0000_000C);
        check_output("stall.id_instr", id_instr[0], 32'hA000_0003);
        check_output("stall.fetch_count", fetch_count[0], 32'd3);
        check_output("stall.imem_en", {31'b0, imem_en[0]}, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("unstall.id_pc", id_pc[0], 32'h0000_0010);
        check_output("unstall.fetch_count", fetch_count[0], 32'd4);

        // Redirect to 0x40; redirect is still asserted during these checks.
        apply_stimulus(1'b0, 1'b1, 32'h0000_0040);
        check_output("redir.id_pc", id_pc[0], 32'h0000_0040);
        check_output("redir.id_instr", id_instr[0], 32'hA000_0010);
        check_output("redir_nods.id_pc", id_pc[1], 32'h0000_0040);
        check_output("redir_nods.id_valid", {31'b0, id_valid[1]}, 32'h0);
        check_output("redir.imem_addr", imem_addr[0], 32'h0000_0040);

        // Redirect wins over a simultaneous stall.
        apply_stimulus(1'b1, 1'b1, 32'h0000_0080);
        check_output("redir_stall.imem_en", {31'b0, imem_en[0]}, 32'h1);
        check_output("redir_stall.imem_addr", imem_addr[0], 32'h0000_0080);
        check_output("redir_stall.id_pc", id_pc[0], 32'h0000_0080);

        // Misaligned target is forced to a word boundary and latches the error.
        apply_stimulus(1'b0, 1'b1, 32'h0000_0043);
        check_output("misalign.imem_addr", imem_addr[0], 32'h0000_0040);
        check_output("misalign.err", {31'b0, misalign_err[0]}, 32'h1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("misalign.sticky0", {31'b0, misalign_err[0]}, 32'h1);
        check_output("misalign.sticky2", {31'b0, misalign_err[2]}, 32'h1);

        run_random(300);

        // Asynchronous reset pulse off the clock edge, mid-stream with stall/redirect live.
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0123;
        #2 reset = 1'b0;
        #1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        check_reset_state("midreset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        repeat (4) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("rerun.fetch_count", fetch_count[0], 32'd3);
        check_output("rerun.misalign_err", {31'b0, misalign_err[0]}, 32'h0);
        run_random(300);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
